// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table capture block.
package tt_pkg;

  localparam int N_IN_DEF = 4;
  localparam int DEPTH    = 1 << N_IN_DEF;

  typedef enum logic [1:0] {
    TT_IDLE,
    TT_CAPTURE,
    TT_CHECK,
    TT_DONE
  } tt_state_e;

endpackage

// File: rtl/tt_idle_timer.sv
// Idle-cycle counter for the capture phase; tc flags the last permitted idle cycle.
// TIMEOUT_CYC = 0 removes the counter and holds tc low.
module tt_idle_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign tc            = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYC + 1);

      logic [W-1:0] count;

      assign tc = enable && (count == W'(TIMEOUT_CYC - 1));

      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          count <= '0;
        end else if (enable && !tc) begin
          count <= count + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/truth_table_capture.sv
// Rebuilds a 2**N_IN-entry truth table from (vec, y) samples and checks it against EXPECTED.
// Optional macro TT_MISMATCH_LOG_EN adds first_bad_idx / bad_count diagnostic outputs.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int                     N_IN        = N_IN_DEF,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED    = 16'h6996,
  parameter int                     TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   vec_valid,
  output logic                   vec_ready,
  input  logic [N_IN-1:0]        vec,
  input  logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   covered,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   dup_err,
  output logic                   timeout_err
`ifdef TT_MISMATCH_LOG_EN
  ,
  output logic [N_IN-1:0]        first_bad_idx,
  output logic [N_IN:0]          bad_count
`endif
);

  localparam int DEPTH_L = 1 << N_IN;

  tt_state_e            state_q, state_d;
  logic                 in_capture;
  logic                 xfer;
  logic                 start_ok;
  logic                 idle_tc;
  logic [DEPTH_L-1:0]   next_covered;

  assign in_capture   = (state_q == TT_CAPTURE);
  assign xfer         = vec_valid && in_capture;
  assign start_ok     = start && ((state_q == TT_IDLE) || (state_q == TT_DONE));
  assign next_covered = covered | (xfer ? (DEPTH_L'(1) << vec) : '0);

  tt_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok || xfer),
    .enable (in_capture),
    .tc     (idle_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= TT_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      TT_IDLE: begin
        if (start) state_d = TT_CAPTURE;
      end
      TT_CAPTURE: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        // A transfer on the terminal idle cycle takes priority over the timeout.
        if (xfer && (&next_covered)) state_d = TT_CHECK;
        else if (!xfer && idle_tc)   state_d = TT_DONE;
      end
      TT_CHECK: begin
        busy    = 1'b1;
        state_d = TT_DONE;
      end
      TT_DONE: begin
        done = 1'b1;
        if (start) state_d = TT_CAPTURE;
      end
      default: state_d = TT_IDLE;
    endcase
  end

`ifdef TT_MISMATCH_LOG_EN
  logic [DEPTH_L-1:0] diff;
  logic [N_IN-1:0]    first_bad_c;
  logic [N_IN:0]      bad_count_c;

  assign diff = table_out ^ EXPECTED;

  // Scan downward so the lowest mismatching index is the one left standing.
  always_comb begin
    first_bad_c = '0;
    bad_count_c = '0;
    for (int i = DEPTH_L - 1; i >= 0; i--) begin
      if (diff[i]) first_bad_c = i[N_IN-1:0];
      bad_count_c = bad_count_c + {{N_IN{1'b0}}, diff[i]};
    end
  end
`endif

  // NOTE: table_out and covered are plain flop vectors, so they are reset like any other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      covered     <= '0;
      table_out   <= '0;
      dup_err     <= 1'b0;
      timeout_err <= 1'b0;
      pass        <= 1'b0;
`ifdef TT_MISMATCH_LOG_EN
      first_bad_idx <= '0;
      bad_count     <= '0;
`endif
    end else begin
      case (state_q)
        TT_IDLE, TT_DONE: begin
          if (start) begin
            covered     <= '0;
            table_out   <= '0;
            dup_err     <= 1'b0;
            timeout_err <= 1'b0;
            pass        <= 1'b0;
`ifdef TT_MISMATCH_LOG_EN
            first_bad_idx <= '0;
            bad_count     <= '0;
`endif
          end
        end
        TT_CAPTURE: begin
          if (xfer) begin
            covered <= next_covered;
            if (!covered[vec]) begin
              table_out[vec] <= y;
            end else if (table_out[vec] != y) begin
              dup_err <= 1'b1;
            end
          end else if (idle_tc) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
          end
        end
        TT_CHECK: begin
          pass <= (table_out == EXPECTED) && !dup_err;
`ifdef TT_MISMATCH_LOG_EN
          first_bad_idx <= first_bad_c;
          bad_count     <= bad_count_c;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture: stimulus pushes expected results, a monitor
// compares them each time done rises. Also exercises TT_MISMATCH_LOG_EN outputs when defined.
module tb_truth_table_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [3:0]  vec = '0;
  logic        y = 1'b0;
  logic        busy, done, pass, dup_err, timeout_err;
  logic [15:0] covered, table_out;
`ifdef TT_MISMATCH_LOG_EN
  logic [3:0]  first_bad_idx;
  logic [4:0]  bad_count;
`endif

  always #5 clk = ~clk;

  truth_table_capture dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec         (vec),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .covered     (covered),
    .table_out   (table_out),
    .dup_err     (dup_err),
    .timeout_err (timeout_err)
`ifdef TT_MISMATCH_LOG_EN
    ,
    .first_bad_idx (first_bad_idx),
    .bad_count     (bad_count)
`endif
  );

  typedef struct {
    string       tag;
    logic        pass;
    logic [15:0] cov;
    logic [15:0] tbl;
    logic        dup;
    logic        tmo;
    int          lat;
    logic [3:0]  fbi;
    logic [4:0]  bc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_xfer = 0;
  bit   done_q   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string tag, input logic p, input logic [15:0] cv,
                          input logic [15:0] tb, input logic d, input logic t, input int lat,
                          input logic [3:0] fbi, input logic [4:0] bc);
    exp_t e;
    e.tag = tag; e.pass = p; e.cov = cv; e.tbl = tb; e.dup = d; e.tmo = t;
    e.lat = lat; e.fbi = fbi; e.bc = bc;
    sb_q.push_back(e);
  endtask

  // Latency is counted in cycles: completing-transfer cycle -> CHECK cycle -> first DONE cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (vec_valid && vec_ready && !rst) last_xfer = cyc;
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        check("spurious_done_queue_len", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_pass"},        pass,            e.pass);
        check({e.tag, "_covered"},     covered,         e.cov);
        check({e.tag, "_table_out"},   table_out,       e.tbl);
        check({e.tag, "_dup_err"},     dup_err,         e.dup);
        check({e.tag, "_timeout_err"}, timeout_err,     e.tmo);
        check({e.tag, "_latency"},     cyc - last_xfer, e.lat);
`ifdef TT_MISMATCH_LOG_EN
        check({e.tag, "_first_bad_idx"}, first_bad_idx, e.fbi);
        check({e.tag, "_bad_count"},     bad_count,     e.bc);
`endif
      end
    end
    done_q = done;
  end

  task automatic send(input logic [3:0] v, input logic yv);
    int n = 0;
    vec = v; y = yv; vec_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!vec_ready && n < 50);
    if (!vec_ready) check("send_ready_wait", vec_ready, 1);
    @(posedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", done, 1);
  endtask

  // Hand-picked order covering all 16 indices, with idle gaps kept well under 64.
  localparam logic [3:0] PERM [16] = '{9, 2, 14, 0, 7, 11, 4, 15, 1, 12, 6, 3, 10, 5, 13, 8};
  localparam int         GAPS [16] = '{0, 3, 1, 40, 0, 7, 2, 0, 25, 1, 0, 5, 12, 0, 3, 0};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_vec_ready",   vec_ready,   0);
    check("reset_busy",        busy,        0);
    check("reset_done",        done,        0);
    check("reset_pass",        pass,        0);
    check("reset_covered",     covered,     0);
    check("reset_table_out",   table_out,   0);
    check("reset_dup_err",     dup_err,     0);
    check("reset_timeout_err", timeout_err, 0);

    // 1: in-order XOR sweep, back-to-back transfers.
    pulse_start();
    push_exp("sweep", 1, 16'hFFFF, 16'h6996, 0, 0, 2, 4'd0, 5'd0);
    for (int v = 0; v < 16; v++) send(4'(v), ^(4'(v)));
    wait_done(20);

    // 2: index 5 should be 0; drive it to 1 instead.
    pulse_start();
    push_exp("bad_idx5", 0, 16'hFFFF, 16'h69B6, 0, 0, 2, 4'd5, 5'd1);
    for (int v = 0; v < 16; v++) send(4'(v), (v == 5) ? 1'b1 : ^(4'(v)));
    wait_done(20);

    // 3: index 3 first with the wrong y=1, then correct y=0; first value is kept.
    pulse_start();
    push_exp("dup_idx3", 0, 16'hFFFF, 16'h699E, 1, 0, 2, 4'd3, 5'd1);
    send(4'd3, 1'b1);
    send(4'd3, 1'b0);
    for (int v = 0; v < 16; v++) if (v != 3) send(4'(v), ^(4'(v)));
    wait_done(20);

    // 4: stop after ten samples and let the idle timer expire.
    pulse_start();
    push_exp("timeout", 0, 16'h03FF, 16'h0196, 0, 1, 65, 4'd0, 5'd0);
    for (int v = 0; v < 10; v++) send(4'(v), ^(4'(v)));
    wait_done(100);

    // 5: reset mid-capture, then a clean run.
    pulse_start();
    for (int v = 0; v < 8; v++) send(4'(v), ^(4'(v)));
    check("pre_reset_covered", covered, 16'h00FF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_vec_ready", vec_ready, 0);
    check("midrst_busy",      busy,      0);
    check("midrst_covered",   covered,   0);
    check("midrst_table_out", table_out, 0);
    pulse_start();
    push_exp("after_reset", 1, 16'hFFFF, 16'h6996, 0, 0, 2, 4'd0, 5'd0);
    for (int v = 0; v < 16; v++) send(4'(v), ^(4'(v)));
    wait_done(20);

    // 6: shuffled order with gaps and a start pulse mid-capture that must be ignored.
    pulse_start();
    push_exp("shuffled", 1, 16'hFFFF, 16'h6996, 0, 0, 2, 4'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      send(PERM[i], ^PERM[i]);
      if (i == 4) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      repeat (GAPS[i]) @(posedge clk);
      #1;
    end
    wait_done(80);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
